// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: scan scheduler that time-shares one hex 7-seg decoder
// across DIGITS positions, with a tear-free display register and guard gaps.

// Per-digit leading-zero blank: this digit and everything above it are zero.
module hex_scan_lane #(
  parameter int W   = 4,
  parameter bit LSD = 1'b0
) (
  input  logic [W-1:0] upper,
  input  logic         lz,
  output logic         blank
);
  // digit 0 is never blanked, so a zero display still shows a single '0'
  assign blank = lz & ~LSD & (upper == '0);
endmodule

module hex_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_suppress,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [3:0]            nibble_out,
  output logic                  seg_blank,
  output logic [DIGITS-1:0]     dig_sel_n,
  output logic                  frame_done
);
  localparam int MAXC = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = $clog2(MAXC);
  localparam int IW   = $clog2(DIGITS);
  localparam logic [CW-1:0] G_LAST   = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_SHOW} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [DIGITS-1:0][3:0]  disp, disp_n, pend_data;
  logic                    pend, pend_n;
  logic                    accept, commit, wrap;
  logic [DIGITS-1:0]       blank_vec;
  logic [3:0]              nibble_x;
  logic                    seg_blank_x;
  logic [DIGITS-1:0]       dig_sel_x;

  assign load_ready = ~pend;
  assign accept     = load_valid & ~pend;

  // Next scan position: IDLE -> GUARD -> SHOW -> GUARD ..., en low forces IDLE
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap    = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_GUARD;
          idx_n   = '0;
          cnt_n   = '0;
        end
        ST_GUARD: begin
          if (cnt == G_LAST) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == D_LAST) begin
            state_n = ST_GUARD;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Pending value moves into disp only between frames or while idle
  always_comb begin
    commit = pend & (wrap | (state == ST_IDLE));
    disp_n = commit ? pend_data : disp;
    pend_n = pend;
    if (commit)      pend_n = 1'b0;
    else if (accept) pend_n = 1'b1;
  end

  // Blank flags are computed on the value that will be on display next cycle
  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    hex_scan_lane #(
      .W   (4 * (DIGITS - i)),
      .LSD (i == 0)
    ) u_lane (
      .upper (disp_n[DIGITS-1:i]),
      .lz    (lz_suppress),
      .blank (blank_vec[i])
    );
  end

  // Output values for the state being entered, so registered outputs track state
  always_comb begin
    nibble_x    = '0;
    seg_blank_x = 1'b1;
    dig_sel_x   = '1;
    case (state_n)
      ST_GUARD: nibble_x = disp_n[idx_n];
      ST_SHOW: begin
        nibble_x         = disp_n[idx_n];
        seg_blank_x      = blank_vec[idx_n];
        dig_sel_x[idx_n] = 1'b0;
      end
      default: ;
    endcase
  end

  // Scan position and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      disp      <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      disp  <= disp_n;
      pend  <= pend_n;
      if (accept) pend_data <= load_data;
    end
  end

  // Registered drive to decoder and digit selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble_out <= '0;
      seg_blank  <= 1'b1;
      dig_sel_n  <= '1;
      frame_done <= 1'b0;
    end else begin
      nibble_out <= nibble_x;
      seg_blank  <= seg_blank_x;
      dig_sel_n  <= dig_sel_x;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with DIGITS=4, DIV=4, GUARD=1.
module tb_hex_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_suppress;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  nibble_out;
  logic        seg_blank;
  logic [3:0]  dig_sel_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  hex_scan_ctrl #(.DIGITS(4), .DIV(4), .GUARD(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lz_suppress (lz_suppress),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .nibble_out  (nibble_out),
    .seg_blank   (seg_blank),
    .dig_sel_n   (dig_sel_n),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk ncyc cycles of a frame (5 cycles per digit: 1 guard + 4 lit),
  // checking {frame_done, load_ready, seg_blank, dig_sel_n, nibble_out}.
  // Optionally issue a load after the check of cycle inj_c.
  task automatic frame(input logic [15:0] dv, input bit first, input bit lz,
                       input int ncyc, input int inj_c, input logic [15:0] inj_d);
    for (int c = 0; c < ncyc; c++) begin
      int d, p;
      logic [3:0] nib, dig;
      logic sb, fd, rdy;
      d   = c / 5;
      p   = c % 5;
      nib = 4'((dv >> (4 * d)) & 16'hF);
      if (p == 0) begin
        dig = 4'hF;
        sb  = 1'b1;
      end else begin
        dig = ~(4'b0001 << d);
        sb  = lz && (d != 0) && ((dv >> (4 * d)) == 16'h0);
      end
      fd  = (c == 0) && !first;
      rdy = !((inj_c >= 0) && (c > inj_c));
      chk($sformatf("frm%h c%0d", dv, c),
          {21'd0, frame_done, load_ready, seg_blank, dig_sel_n, nibble_out},
          {21'd0, fd, rdy, sb, dig, nib});
      if (c == inj_c) begin
        load_data  = inj_d;
        load_valid = 1'b1;
      end
      tick();
      load_valid = 1'b0;
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " sel"},   {28'd0, dig_sel_n},  32'hF);
    chk({tag, " blank"}, {31'd0, seg_blank},  32'd1);
    chk({tag, " nib"},   {28'd0, nibble_out}, 32'd0);
    chk({tag, " fd"},    {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lz_suppress = 1'b0; load_data = '0; load_valid = 1'b0;
    #3;
    // reset state
    chk_dark("rst");
    chk("rst rdy", {31'd0, load_ready}, 32'd1);
    tick();
    rst = 1'b0;

    // load while idle: accept, then commit on next edge
    load_data = 16'h1234; load_valid = 1'b1;
    chk("idle rdy0", {31'd0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    chk("idle pend", {31'd0, load_ready}, 32'd0);
    chk_dark("idle");
    tick();
    chk("idle commit", {31'd0, load_ready}, 32'd1);
    en = 1'b1;
    tick();

    // two full frames of 1234
    frame(16'h1234, 1'b1, 1'b0, 20, -1, 16'h0);
    frame(16'h1234, 1'b0, 1'b0, 20, -1, 16'h0);
    // mid-frame load: frame keeps 1234, ABCD appears at frame end
    frame(16'h1234, 1'b0, 1'b0, 20, 7, 16'hABCD);
    frame(16'hABCD, 1'b0, 1'b0, 20, 7, 16'h0050);
    // leading-zero suppression
    lz_suppress = 1'b1;
    frame(16'h0050, 1'b0, 1'b1, 20, 7, 16'h0000);
    frame(16'h0000, 1'b0, 1'b1, 20, -1, 16'h0);

    // drop en during SHOW of idx 2
    lz_suppress = 1'b0;
    frame(16'h0000, 1'b0, 1'b0, 11, -1, 16'h0);
    chk("show2 sel", {28'd0, dig_sel_n}, 32'hB);
    en = 1'b0;
    tick();
    chk_dark("en0 a");
    load_data = 16'h9876; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_dark("en0 b");
    tick();
    chk("en0 commit", {31'd0, load_ready}, 32'd1);
    en = 1'b1;
    tick();
    frame(16'h9876, 1'b1, 1'b0, 20, -1, 16'h0);

    // async reset mid-SHOW with a pending load
    frame(16'h9876, 1'b0, 1'b0, 4, 2, 16'h5555);
    chk("pre-rst pend", {31'd0, load_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_dark("async rst");
    chk("async rst rdy", {31'd0, load_ready}, 32'd1);
    rst = 1'b0;
    tick();
    // disp cleared and the pending 5555 lost across a frame boundary
    frame(16'h0000, 1'b1, 1'b0, 20, -1, 16'h0);
    frame(16'h0000, 1'b0, 1'b0, 5, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
